hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined RISC-V core, sitting beside the ID/EX pipeline register. It tracks the destinations of in-flight instructions in a 3-entry scoreboard (EX, MEM, WB) and produces per-operand forwarding selects for the instruction in ID. It detects load-use hazards and stalls IF/ID for one cycle while issuing a bubble into ID/EX. It also freezes the pipeline on memory back-pressure and flushes on control-flow redirects.

## Interface
- STALL_CNT_W, 32, width of the optional stall counter.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  5  ID source registers.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd_addr  in  5  ID destination.
- id_wb_en  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load (writeback_from_mem).
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_busy  in  1  data memory not ready; the pipeline must hold.
- if_stall  out  1  hold PC and IF/ID.
- if_id_flush  out  1  clear IF/ID to a bubble.
- id_ex_skip  out  1  hold ID/EX contents (drives its skip input).
- id_bubble  out  1  instruction entering ID/EX is a bubble (drives skip_instr_in).
- rs1_fwd_sel, rs2_fwd_sel  out  2  0 register file, 1 prev1 (EX result), 2 prev2 (MEM result).
- stall_count  out  STALL_CNT_W  only with HAZARD_PERF_EN.

## Operation
- Scoreboard entries: {valid, rd, wb_en, is_load} for EX, MEM and WB.
  - Each advancing cycle: WB<=MEM, MEM<=EX, EX<=issued ID entry.
  - The EX entry is invalid when id_bubble=1 or id_valid=0.
- An entry matches a source when all hold: valid, wb_en, rd==src, src!=0, src_used.
- fwd_sel is combinational for the ID instruction and is registered by ID/EX:
  - EX-entry match gives 1.
  - Otherwise a MEM-entry match gives 2.
  - Otherwise 0. The WB stage is covered by register-file write-through.
- Load-use: an EX-entry match with is_load=1 and id_valid=1.
- FSM states:
  - RUN: normal flow.
    - mem_busy goes to FREEZE.
    - Otherwise ex_redirect: if_id_flush=1, id_bubble=1; stay in RUN.
    - Otherwise load-use: if_stall=1, id_bubble=1; go to LU_STALL.
  - LU_STALL: exactly one cycle. The scoreboard has advanced, so the load is now in MEM and fwd_sel=2. Return to RUN. mem_busy here goes to FREEZE.
  - FREEZE: if_stall=1, id_ex_skip=1, scoreboard holds. Return to RUN when mem_busy=0, then re-evaluate hazards.
- Priority: rst > mem_busy > ex_redirect > load-use.
- ex_redirect is ignored while mem_busy=1. EX is frozen, so the redirect stays asserted until sampled.
- Outputs not listed for a state are 0.

## Timing
- Reset (rst=0 at a clk edge):
  - state=RUN; all scoreboard valid bits=0; stall_count=0.
  - All outputs 0 during and after reset until inputs dictate otherwise.
- Control outputs and fwd_sel are combinational from the current state, scoreboard and ID/EX/MEM inputs. No added latency.
- A load-use hazard costs exactly 1 bubble.
- Redirect costs 2 squashed slots: the IF/ID flush plus the ID bubble.
- Reset during LU_STALL or FREEZE returns to RUN next cycle with the scoreboard cleared.
- rd=x0 never matches, never forwards and never stalls.

## Configuration
- HAZARD_PERF_EN:
  - Defined: stall_count increments by 1 on every clk edge where if_stall=1 and rst=1. It saturates at all-ones (no wrap) and clears on reset.
  - Undefined: the port and counter are absent.

## Test plan
- Load-use hazard:
  - Stimulus: load x5 in ID, then a dependent add x6,x5,x1 in ID.
  - Response: if_stall=1 and id_bubble=1 for 1 cycle, then rs1_fwd_sel=2, then RUN.
- Back-to-back ALU forwarding:
  - Stimulus: an ALU op writing x3, followed by a consumer using x3 as rs2, then a second consumer 2 slots later.
  - Response: rs2_fwd_sel=1 for the first consumer, 2 for the second, with no stall.
- Writes to x0:
  - Stimulus: a load writing x0, then a consumer of x0.
  - Response: no stall, fwd_sel=0.
- Memory back-pressure:
  - Stimulus: mem_busy high for 3 cycles in the middle of a dependency chain.
  - Response: if_stall=id_ex_skip=1 for 3 cycles and the scoreboard unchanged; forwarding is correct after release.
- Redirect colliding with load-use:
  - Stimulus: ex_redirect=1 in the same cycle as a load-use hazard.
  - Response: if_id_flush=1, id_bubble=1, if_stall=0, stays in RUN.
- Reset during stall, with HAZARD_PERF_EN defined:
  - Stimulus: rst=0 while in LU_STALL.
  - Response: state=RUN, all outputs 0, stall_count=0.
  - Then 5 stall cycles give stall_count=5.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Scoreboard-based forwarding, load-use stall, memory freeze and
//            redirect flush control. Optional stall counter: HAZARD_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
`ifdef HAZARD_PERF_EN
#(
    parameter int STALL_CNT_W = 32
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_id_valid,
    input  logic [4:0]             i_id_rs1_addr,
    input  logic [4:0]             i_id_rs2_addr,
    input  logic                   i_id_rs1_used,
    input  logic                   i_id_rs2_used,
    input  logic [4:0]             i_id_rd_addr,
    input  logic                   i_id_wb_en,
    input  logic                   i_id_is_load,
    input  logic                   i_ex_redirect,
    input  logic                   i_mem_busy,
    output logic                   o_if_stall,
    output logic                   o_if_id_flush,
    output logic                   o_id_ex_skip,
    output logic                   o_id_bubble,
    output logic [1:0]             o_rs1_fwd_sel,
    output logic [1:0]             o_rs2_fwd_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] o_stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wb;
        logic       ld;
    } sb_ent_t;

    state_t  r_state;
    state_t  w_state_next;
    sb_ent_t r_sb [3];   // 0 = EX, 1 = MEM, 2 = WB

    logic       w_ex_hit1;
    logic       w_ex_hit2;
    logic       w_mem_hit1;
    logic       w_mem_hit2;
    logic       w_load_use;
    logic       w_advance;
    logic       w_if_stall;
    logic       w_if_id_flush;
    logic       w_id_ex_skip;
    logic       w_id_bubble;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    function automatic logic f_match(input sb_ent_t e, input logic [4:0] src,
                                     input logic used);
        return e.v && e.wb && (e.rd == src) && (src != 5'd0) && used;
    endfunction

    always_comb begin
        w_ex_hit1  = f_match(r_sb[0], i_id_rs1_addr, i_id_rs1_used);
        w_ex_hit2  = f_match(r_sb[0], i_id_rs2_addr, i_id_rs2_used);
        w_mem_hit1 = f_match(r_sb[1], i_id_rs1_addr, i_id_rs1_used);
        w_mem_hit2 = f_match(r_sb[1], i_id_rs2_addr, i_id_rs2_used);
        w_fwd1     = w_ex_hit1 ? 2'd1 : (w_mem_hit1 ? 2'd2 : 2'd0);
        w_fwd2     = w_ex_hit2 ? 2'd1 : (w_mem_hit2 ? 2'd2 : 2'd0);
        w_load_use = i_id_valid && r_sb[0].ld && (w_ex_hit1 || w_ex_hit2);
    end

    // A released FREEZE evaluates hazards in the same cycle, exactly like RUN.
    always_comb begin
        w_state_next  = r_state;
        w_advance     = 1'b0;
        w_if_stall    = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_skip  = 1'b0;
        w_id_bubble   = 1'b0;
        if (i_mem_busy) begin
            w_if_stall   = 1'b1;
            w_id_ex_skip = 1'b1;
            w_state_next = ST_FREEZE;
        end else begin
            w_advance    = 1'b1;
            w_state_next = ST_RUN;
            case (r_state)
                ST_LU_STALL: begin
                end
                default: begin
                    if (i_ex_redirect) begin
                        w_if_id_flush = 1'b1;
                        w_id_bubble   = 1'b1;
                    end else if (w_load_use) begin
                        w_if_stall    = 1'b1;
                        w_id_bubble   = 1'b1;
                        w_state_next  = ST_LU_STALL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r_sb[i] <= '0;
            end
        end else if (w_advance) begin
            r_sb[2] <= r_sb[1];
            r_sb[1] <= r_sb[0];
            r_sb[0] <= '{v:  i_id_valid && !w_id_bubble,
                         rd: i_id_rd_addr,
                         wb: i_id_wb_en,
                         ld: i_id_is_load};
        end
    end

    // Outputs are forced low while reset is asserted.
    assign o_if_stall    = rst && w_if_stall;
    assign o_if_id_flush = rst && w_if_id_flush;
    assign o_id_ex_skip  = rst && w_id_ex_skip;
    assign o_id_bubble   = rst && w_id_bubble;
    assign o_rs1_fwd_sel = rst ? w_fwd1 : 2'd0;
    assign o_rs2_fwd_sel = rst ? w_fwd2 : 2'd0;

`ifdef HAZARD_PERF_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_if_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_count = rst ? r_stall_cnt : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed test-plan sequences plus random traffic,
// checked against a queue-based reference model through a scoreboard.
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_used, rs2_used, wb_en, is_load, redirect, mem_busy;
    logic        if_stall, if_id_flush, id_ex_skip, id_bubble;
    logic [1:0]  fwd1, fwd2;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_id_valid    (id_valid),
        .i_id_rs1_addr (rs1),
        .i_id_rs2_addr (rs2),
        .i_id_rs1_used (rs1_used),
        .i_id_rs2_used (rs2_used),
        .i_id_rd_addr  (rd),
        .i_id_wb_en    (wb_en),
        .i_id_is_load  (is_load),
        .i_ex_redirect (redirect),
        .i_mem_busy    (mem_busy),
        .o_if_stall    (if_stall),
        .o_if_id_flush (if_id_flush),
        .o_id_ex_skip  (id_ex_skip),
        .o_id_bubble   (id_bubble),
        .o_rs1_fwd_sel (fwd1),
        .o_rs2_fwd_sel (fwd2)
`ifdef HAZARD_PERF_EN
        ,
        .o_stall_count (stall_count)
`endif
    );

`ifndef HAZARD_PERF_EN
    assign stall_count = 32'd0;
`endif

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wb;
        bit       ld;
    } ent_t;

    typedef struct {
        bit [7:0]  ctl;   // {stall, flush, skip, bubble, fwd1, fwd2}
        bit [31:0] cnt;
    } exp_t;

    exp_t      expq[$];
    ent_t      pipe[$];   // in-flight instructions, youngest (EX) first
    bit        lu_pend;
    bit [31:0] m_cnt;
    int        compared   = 0;
    int        mismatched = 0;

    function automatic bit hit(input ent_t e, input bit [4:0] s, input bit u);
        return e.v && e.wb && (e.rd == s) && (s != 5'd0) && u;
    endfunction

    function automatic bit [1:0] fwd_of(input bit [4:0] s, input bit u);
        if (hit(pipe[0], s, u)) return 2'd1;
        if (hit(pipe[1], s, u)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic clear_model();
        ent_t z = '{0, 0, 0, 0};
        pipe.delete();
        repeat (3) pipe.push_back(z);
        lu_pend = 0;
        m_cnt   = 0;
    endtask

    task automatic step(input bit r, input bit vld, input bit [4:0] s1, input bit u1,
                        input bit [4:0] s2, input bit u2, input bit [4:0] d,
                        input bit wb, input bit ld, input bit redir, input bit busy);
        exp_t     e;
        ent_t     n;
        bit       st = 0, fl = 0, sk = 0, bu = 0, adv = 0;
        bit [1:0] f1, f2;
        @(posedge clk);
        #1;
        rst = r; id_valid = vld; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
        rd = d; wb_en = wb; is_load = ld; redirect = redir; mem_busy = busy;
        if (!r) begin
            e.ctl = 8'd0;
            e.cnt = 32'd0;
            expq.push_back(e);
            clear_model();
            return;
        end
        f1 = fwd_of(s1, u1);
        f2 = fwd_of(s2, u2);
        if (busy) begin
            st = 1; sk = 1;
            lu_pend = 0;
        end else begin
            adv = 1;
            if (lu_pend) begin
                lu_pend = 0;
            end else if (redir) begin
                fl = 1; bu = 1;
            end else if (vld && pipe[0].ld && (f1 == 2'd1 || f2 == 2'd1)) begin
                st = 1; bu = 1; lu_pend = 1;
            end
        end
        e.ctl = {st, fl, sk, bu, f1, f2};
        e.cnt = m_cnt;
        expq.push_back(e);
        if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (adv) begin
            n = '{vld && !bu, d, wb, ld};
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
    endtask

    task automatic idle(input bit busy);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        exp_t     e;
        bit [7:0] got;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                got = {if_stall, if_id_flush, id_ex_skip, id_bubble, fwd1, fwd2};
                compared++;
                if (got !== e.ctl) begin
                    mismatched++;
                    $display("FAIL ctl {stall,flush,skip,bubble,fwd1,fwd2} @%0t: got %b required %b",
                             $time, got, e.ctl);
                end
`ifdef HAZARD_PERF_EN
                compared++;
                if (stall_count !== e.cnt) begin
                    mismatched++;
                    $display("FAIL stall_count @%0t: got %0d required %0d",
                             $time, stall_count, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        rst = 0; id_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
        wb_en = 0; is_load = 0; redirect = 0; mem_busy = 0;
        clear_model();
        step(0, 1, 5, 1, 5, 1, 5, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // load x5 ; add x6,x5,x1 -> one bubble then MEM forward
        step(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        step(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        idle(0);

        // ALU x3 ; consumer rs2=x3 ; consumer rs2=x3 two slots after producer
        step(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        step(1, 1, 4, 1, 3, 1, 7, 1, 0, 0, 0);
        step(1, 1, 4, 1, 3, 1, 8, 1, 0, 0, 0);
        idle(0);

        // load into x0 ; consumer of x0
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0);
        idle(0);

        // mem_busy for 3 cycles in a dependency chain
        step(1, 1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        repeat (3) step(1, 1, 3, 1, 0, 0, 4, 1, 0, 1, 1);
        step(1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
        step(1, 1, 4, 1, 3, 1, 5, 1, 0, 0, 0);
        idle(0);

        // redirect together with load-use
        step(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(1, 1, 5, 1, 0, 0, 6, 1, 0, 1, 0);
        idle(0);

        // reset while in LU_STALL, then five stall cycles
        step(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        step(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        idle(0);
        repeat (5) idle(1);
        idle(0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) != 0),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(posedge clk);
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending responses required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
